cpld_ctrl_axil_serial: RTL

//  AXI4-Lite register slave, next generation of the 4-register CPLD control block: NUM_REGS registers

---
 rtl/cpld_ctrl_axil_serial.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/cpld_ctrl_axil_serial.sv
// AXI4-Lite register slave with a serial shift engine towards the board CPLD.
// Optional macro CPLD_CTRL_IRQ_EN adds CTRL[1] IRQ_ENA and a registered level irq.
`timescale 1ns/1ps
module cpld_ctrl_axil_serial #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned SHIFT_W  = 32,
    parameter int unsigned DIV_RST  = 4
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [ADDR_W-1:0] S_AXI_AWADDR,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,
    input  logic [31:0]       S_AXI_WDATA,
    input  logic [3:0]        S_AXI_WSTRB,
    input  logic              S_AXI_WVALID,
    output logic              S_AXI_WREADY,
    output logic [1:0]        S_AXI_BRESP,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,
    input  logic [ADDR_W-1:0] S_AXI_ARADDR,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,
    output logic [31:0]       S_AXI_RDATA,
    output logic [1:0]        S_AXI_RRESP,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY,
    output logic              cpld_cs_n,
    output logic              cpld_sclk,
    output logic              cpld_sdo,
    input  logic              cpld_sdi,
    output logic              irq
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LOW, S_HIGH, S_FINISH} state_t;

    state_t              state, state_nxt;
    logic                aw_ready, w_ready, b_valid, ar_ready, r_valid;
    logic [1:0]          b_resp, r_resp;
    logic [31:0]         r_data;
    logic                aw_held, w_held;
    logic [ADDR_W-3:0]   aw_idx;
    logic [31:0]         w_data;
    logic [3:0]          w_strb;
    logic [31:0]         regs [NUM_REGS];
    logic [7:0]          clkdiv;
    logic                done, done_nxt, busy, ctrl_b1;
    logic [7:0]          div_l, div_cnt;
    logic [5:0]          bit_cnt;
    logic [SHIFT_W-1:0]  tx_sh, rx_sh;
    logic [31:0]         rxdata;
    logic                cs_n_q, sclk_q, sdo_q;
    logic                do_write, wr_ok, go_req, w1c, phase_end, last_bit;
    logic [31:0]         wr_idx, rd_idx, rd_val;
    logic                rd_ok;
    logic                unused_addr_lsb;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int unsigned b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    assign do_write = aw_held && w_held && !b_valid;
    assign wr_idx   = 32'(aw_idx);
    assign wr_ok    = (wr_idx < NUM_REGS) && (wr_idx != 32'd3);
    assign go_req   = do_write && (wr_idx == 32'd0) && w_strb[0] && w_data[0];
    assign w1c      = do_write && (wr_idx == 32'd1) && w_strb[0] && w_data[1];
    assign busy     = (state != S_IDLE);
    assign phase_end = (div_cnt == div_l);
    assign last_bit  = (bit_cnt == 6'(SHIFT_W - 1));

`ifdef CPLD_CTRL_IRQ_EN
    logic irq_ena, irq_ena_nxt, irq_q;
    assign ctrl_b1 = irq_ena;
    assign irq     = irq_q;
    always_comb begin
        irq_ena_nxt = irq_ena;
        if (do_write && (wr_idx == 32'd0) && w_strb[0]) irq_ena_nxt = w_data[1];
    end
    // irq follows the next-cycle DONE so it drops on the same edge as a W1C
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            irq_ena <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            irq_ena <= irq_ena_nxt;
            irq_q   <= done_nxt && irq_ena_nxt;
        end
    end
`else
    assign ctrl_b1 = 1'b0;
    assign irq     = 1'b0;
`endif

    // Engine next-state; FINISH setting DONE overrides a same-cycle W1C
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (go_req) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_LOW;
            S_LOW:    if (phase_end) state_nxt = S_HIGH;
            S_HIGH:   if (phase_end) state_nxt = last_bit ? S_FINISH : S_LOW;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        done_nxt = done;
        if (w1c) done_nxt = 1'b0;
        if (state == S_FINISH) done_nxt = 1'b1;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state   <= S_IDLE;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            sdo_q   <= 1'b0;
            div_l   <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            rxdata  <= '0;
        end else begin
            state  <= state_nxt;
            cs_n_q <= !(state_nxt == S_LOW || state_nxt == S_HIGH);
            sclk_q <= (state_nxt == S_HIGH);
            if (state_nxt != state) div_cnt <= '0;
            else if (state == S_LOW || state == S_HIGH) div_cnt <= div_cnt + 8'd1;
            case (state)
                S_LOAD: begin
                    div_l   <= clkdiv;
                    sdo_q   <= regs[2][SHIFT_W-1];
                    tx_sh   <= regs[2][SHIFT_W-1:0] << 1;
                    bit_cnt <= '0;
                    rx_sh   <= '0;
                end
                S_LOW: if (phase_end) rx_sh <= SHIFT_W'({rx_sh, cpld_sdi});
                S_HIGH: if (phase_end) begin
                    if (last_bit) begin
                        sdo_q <= 1'b0;
                    end else begin
                        sdo_q   <= tx_sh[SHIFT_W-1];
                        tx_sh   <= tx_sh << 1;
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                S_FINISH: rxdata <= 32'(rx_sh);
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_idx = 32'(S_AXI_ARADDR[ADDR_W-1:2]);
        rd_ok  = (rd_idx < NUM_REGS);
        rd_val = '0;
        if (rd_idx == 32'd0) rd_val = {16'h0, clkdiv, 6'h0, ctrl_b1, 1'b0};
        if (rd_idx == 32'd1) rd_val = {30'h0, done, busy};
        if (rd_idx == 32'd3) rd_val = rxdata;
        for (int unsigned i = 0; i < NUM_REGS; i++)
            if ((i == 2 || i >= 4) && rd_idx == i) rd_val = regs[i];
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            b_valid  <= 1'b0;
            b_resp   <= 2'b00;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx   <= '0;
            w_data   <= '0;
            w_strb   <= '0;
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_resp   <= 2'b00;
            r_data   <= '0;
            clkdiv   <= 8'(DIV_RST);
            done     <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            aw_ready <= S_AXI_AWVALID && !aw_held && !aw_ready && !b_valid;
            w_ready  <= S_AXI_WVALID && !w_held && !w_ready && !b_valid;
            if (aw_ready && S_AXI_AWVALID) begin
                aw_held <= 1'b1;
                aw_idx  <= S_AXI_AWADDR[ADDR_W-1:2];
            end
            if (w_ready && S_AXI_WVALID) begin
                w_held <= 1'b1;
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
            if (do_write) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                b_valid <= 1'b1;
                b_resp  <= wr_ok ? 2'b00 : 2'b10;
                if (wr_ok && wr_idx == 32'd0 && w_strb[1]) clkdiv <= w_data[15:8];
                for (int unsigned i = 0; i < NUM_REGS; i++)
                    if ((i == 2 || i >= 4) && wr_idx == i) regs[i] <= merge(regs[i], w_data, w_strb);
            end else if (b_valid && S_AXI_BREADY) begin
                b_valid <= 1'b0;
            end
            done <= done_nxt;
            ar_ready <= S_AXI_ARVALID && !ar_ready && !r_valid;
            if (ar_ready && S_AXI_ARVALID) begin
                r_valid <= 1'b1;
                r_data  <= rd_val;
                r_resp  <= rd_ok ? 2'b00 : 2'b10;
            end else if (r_valid && S_AXI_RREADY) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign unused_addr_lsb = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = w_ready;
    assign S_AXI_BVALID  = b_valid;
    assign S_AXI_BRESP   = b_resp;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = r_valid;
    assign S_AXI_RRESP   = r_resp;
    assign S_AXI_RDATA   = r_data;
    assign cpld_cs_n     = cs_n_q;
    assign cpld_sclk     = sclk_q;
    assign cpld_sdo      = sdo_q;

endmodule
